alu_issue_ctrl: RTL and testbench

- Initiator/sequencer side of alu_core: accepts 9-bit register-register instructions over a valid/ready handshake and reads operands from an internal 8-entry register file.
- Drives alu_core's operand/operation inputs from registers and samples its 2N-bit result.
- Writes the low half back to the destination register and the high half to a HI register.
- Presents each completed result downstream on a valid/ready handshake; sits between the fetch/decode path and alu_core.

---
 rtl/alu_issue_ctrl_if.sv | 35 +++
 rtl/alu_issue_ctrl.sv | 118 +++++++++++
 tb/tb_alu_issue_ctrl.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_ctrl_if.sv
// Handshake and ALU-side bundle between alu_issue_ctrl and its environment
// (fetch/decode, preload port, alu_core, result consumer).
interface alu_issue_ctrl_if #(
    parameter int N = 8
);
    logic             instr_valid;
    logic             instr_ready;
    logic [8:0]       instr;
    logic             ld_valid;
    logic [2:0]       ld_addr;
    logic [N-1:0]     ld_data;
    logic [N-1:0]     alu_operand1;
    logic [N-1:0]     alu_operand2;
    logic [3:0]       alu_operation;
    logic [2*N-1:0]   alu_result;
    logic             res_valid;
    logic             res_ready;
    logic [N-1:0]     res_data;
    logic [N-1:0]     res_hi;
    logic [2:0]       res_rd;
    logic             res_err;

    // The sequencer is the target of the instruction stream.
    modport slave (
        input  instr_valid, instr, ld_valid, ld_addr, ld_data, alu_result, res_ready,
        output instr_ready, alu_operand1, alu_operand2, alu_operation,
        output res_valid, res_data, res_hi, res_rd, res_err
    );

    modport master (
        output instr_valid, instr, ld_valid, ld_addr, ld_data, alu_result, res_ready,
        input  instr_ready, alu_operand1, alu_operand2, alu_operation,
        input  res_valid, res_data, res_hi, res_rd, res_err
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issue sequencer for alu_core: reads operands from an 8-entry register file,
// runs one instruction at a time and commits the result on a valid/ready handshake.
module alu_issue_ctrl #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           reset,
    alu_issue_ctrl_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WB} state_t;

    state_t         r_state;
    state_t         w_next;
    logic [2:0]     r_op;
    logic [2:0]     r_rd;
    logic [2:0]     r_rs;
    logic [N-1:0]   r_regs [8];
    logic [N-1:0]   r_hi;
    logic [N-1:0]   r_op1;
    logic [N-1:0]   r_op2;
    logic [3:0]     r_alu_op;
    logic [N-1:0]   r_res_data;
    logic [N-1:0]   r_res_hi;
    logic [2:0]     r_res_rd;
    logic           r_res_err;

    logic           w_instr_ready;
    logic           w_accept;
    logic           w_res_valid;
    logic           w_commit;
    logic           w_div_zero;

    // Preload owns the IDLE cycle, so it blocks acceptance.
    assign w_instr_ready = (r_state == S_IDLE) && !bus.ld_valid && !reset;
    assign w_accept      = w_instr_ready && bus.instr_valid;
    assign w_res_valid   = (r_state == S_WB) && !reset;
    assign w_commit      = w_res_valid && bus.res_ready;
    assign w_div_zero    = (r_op == 3'b110) && (r_regs[r_rs] == '0);

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // NOTE: default first so every path assigns w_next and no latch is inferred.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next = S_READ;
            S_READ: w_next = w_div_zero ? S_WB : S_EXEC;
            S_EXEC: w_next = S_WB;
            S_WB:   if (w_commit) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // NOTE: non-blocking assignments throughout, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the register file is architecturally cleared on reset, so it is flops, not RAM.
            for (int i = 0; i < 8; i++) r_regs[i] <= '0;
            r_hi       <= '0;
            r_op       <= '0;
            r_rd       <= '0;
            r_rs       <= '0;
            r_op1      <= '0;
            r_op2      <= '0;
            r_alu_op   <= '0;
            r_res_data <= '0;
            r_res_hi   <= '0;
            r_res_rd   <= '0;
            r_res_err  <= 1'b0;
        end else begin
            if ((r_state == S_IDLE) && bus.ld_valid)
                r_regs[bus.ld_addr] <= bus.ld_data;

            if (w_accept) begin
                r_op <= bus.instr[8:6];
                r_rd <= bus.instr[5:3];
                r_rs <= bus.instr[2:0];
            end

            if (r_state == S_READ) begin
                r_op1    <= r_regs[r_rd];
                r_op2    <= r_regs[r_rs];
                r_alu_op <= {1'b0, r_op};
                r_res_rd <= r_rd;
                // Divide-by-zero is resolved here without consulting the ALU.
                if (w_div_zero) begin
                    r_res_data <= '1;
                    r_res_hi   <= '0;
                    r_res_err  <= 1'b1;
                end
            end

            if (r_state == S_EXEC) begin
                r_res_data <= bus.alu_result[N-1:0];
                r_res_hi   <= bus.alu_result[2*N-1:N];
                r_res_err  <= 1'b0;
            end

            if (w_commit) begin
                r_regs[r_res_rd] <= r_res_data;
                if (!r_res_err) r_hi <= r_res_hi;
            end
        end
    end

    assign bus.instr_ready   = w_instr_ready;
    assign bus.alu_operand1  = r_op1;
    assign bus.alu_operand2  = r_op2;
    assign bus.alu_operation = r_alu_op;
    assign bus.res_valid     = w_res_valid;
    assign bus.res_data      = r_res_data;
    assign bus.res_hi        = r_res_hi;
    assign bus.res_rd        = r_res_rd;
    assign bus.res_err       = r_res_err;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl with a behavioural alu_core stand-in.
module tb_alu_issue_ctrl;
    localparam int N = 8;

    typedef struct packed {
        logic [7:0] data;
        logic [7:0] hi;
        logic [2:0] rd;
        logic       err;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];
    logic [7:0] m_regs [8];
    logic [7:0] m_hi;

    always #5 clk = ~clk;

    alu_issue_ctrl_if #(.N(N)) bus ();

    alu_issue_ctrl #(.N(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic logic [15:0] alu_ref(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op[2:0])
            3'd0: return {8'd0, a} + {8'd0, b};
            3'd1: return {8'd0, a & b};
            3'd2: return {8'd0, a} - {8'd0, b};
            3'd3: return {8'd0, a | b};
            3'd4: return {8'd0, a ^ b};
            3'd5: return {8'd0, a} * {8'd0, b};
            3'd6: return (b == 8'd0) ? 16'hFFFF : {a % b, a / b};
            default: return {15'd0, (a < b)};
        endcase
    endfunction

    assign bus.alu_result = alu_ref(bus.alu_operation, bus.alu_operand1, bus.alu_operand2);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!reset && bus.res_valid && bus.res_ready) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("res_data", bus.res_data, e.data);
                check("res_hi",   bus.res_hi,   e.hi);
                check("res_rd",   bus.res_rd,   e.rd);
                check("res_err",  bus.res_err,  e.err);
            end
        end
    end

    // Called and returns in the posedge+1 phase.
    task automatic preload(input logic [2:0] addr, input logic [7:0] data);
        bus.ld_valid = 1'b1;
        bus.ld_addr  = addr;
        bus.ld_data  = data;
        @(posedge clk) #1;
        bus.ld_valid = 1'b0;
        m_regs[addr] = data;
    endtask

    task automatic issue(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs, input int hold);
        exp_t        e;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] r;
        logic        div0;
        logic        ok;
        int          lat;
        a    = m_regs[rd];
        b    = m_regs[rs];
        div0 = (op == 3'b110) && (b == 8'd0);
        if (div0) begin
            e = '{data: 8'hFF, hi: 8'h00, rd: rd, err: 1'b1};
        end else begin
            r = alu_ref({1'b0, op}, a, b);
            e = '{data: r[7:0], hi: r[15:8], rd: rd, err: 1'b0};
        end
        bus.res_ready   = (hold == 0);
        bus.instr       = {op, rd, rs};
        bus.instr_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.instr_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            check("accept_timeout", 32'd0, 32'd1);
            bus.instr_valid = 1'b0;
            bus.res_ready   = 1'b1;
            return;
        end
        sb.push_back(e);
        m_regs[rd] = e.data;
        if (!div0) m_hi = e.hi;
        @(posedge clk) #1;
        bus.instr_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!bus.res_valid && lat < 12) begin
            @(negedge clk);
            lat++;
        end
        check("latency", lat, div0 ? 32'd2 : 32'd3);
        check("alu_operation", bus.alu_operation, {1'b0, op});
        check("alu_operand1", bus.alu_operand1, a);
        check("alu_operand2", bus.alu_operand2, b);
        if (hold > 0) begin
            for (int k = 0; k < hold; k++) begin
                @(posedge clk) #1;
                bus.instr_valid = 1'b1;
                bus.instr       = 9'($urandom_range(0, 511));
                @(negedge clk);
                check("hold_valid", bus.res_valid, 32'd1);
                check("hold_ready", bus.instr_ready, 32'd0);
                check("hold_data", {bus.res_data, bus.res_hi, bus.res_rd, bus.res_err},
                      {e.data, e.hi, e.rd, e.err});
            end
            @(posedge clk) #1;
            bus.instr_valid = 1'b0;
            bus.res_ready   = 1'b1;
            @(negedge clk);
        end
        @(posedge clk) #1;
        @(negedge clk);
        check("ready_after_commit", bus.instr_ready, 32'd1);
        check("valid_after_commit", bus.res_valid, 32'd0);
        check("regfile_rd", dut.r_regs[rd], m_regs[rd]);
        check("hi_reg", dut.r_hi, m_hi);
        @(posedge clk) #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset           = 1'b1;
        bus.instr_valid = 1'b0;
        bus.instr       = '0;
        bus.ld_valid    = 1'b0;
        bus.ld_addr     = '0;
        bus.ld_data     = '0;
        bus.res_ready   = 1'b1;
        m_hi            = '0;
        for (int i = 0; i < 8; i++) m_regs[i] = '0;

        @(posedge clk) #1;
        @(negedge clk);
        check("rst_instr_ready", bus.instr_ready, 32'd0);
        check("rst_res_valid", bus.res_valid, 32'd0);
        @(posedge clk) #1;
        reset = 1'b0;
        @(negedge clk);
        check("idle_instr_ready", bus.instr_ready, 32'd1);
        check("idle_res_valid", bus.res_valid, 32'd0);
        check("idle_outputs", {bus.alu_operand1, bus.alu_operand2, bus.alu_operation,
              bus.res_data, bus.res_hi, bus.res_rd, bus.res_err}, 32'd0);
        @(posedge clk) #1;

        // add with carry into HI, then a dependent sub reading the new R1
        preload(3'd1, 8'd200);
        preload(3'd2, 8'd100);
        issue(3'b000, 3'd1, 3'd2, 0);
        issue(3'b010, 3'd2, 3'd1, 0);

        preload(3'd3, 8'd20);
        preload(3'd4, 8'd15);
        issue(3'b101, 3'd3, 3'd4, 0);

        // divide by zero leaves HI untouched
        preload(3'd5, 8'd9);
        preload(3'd6, 8'd0);
        issue(3'b110, 3'd5, 3'd6, 0);

        // back-pressure on the result port
        issue(3'b100, 3'd7, 3'd3, 5);

        // preload and instruction offered together
        bus.ld_valid    = 1'b1;
        bus.ld_addr     = 3'd0;
        bus.ld_data     = 8'd77;
        bus.instr       = {3'b000, 3'd0, 3'd0};
        bus.instr_valid = 1'b1;
        @(negedge clk);
        check("ld_blocks_ready", bus.instr_ready, 32'd0);
        @(posedge clk) #1;
        bus.ld_valid = 1'b0;
        m_regs[0]    = 8'd77;
        issue(3'b000, 3'd0, 3'd0, 0);

        for (int i = 0; i < 8; i++)
            issue(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 0);

        // reset in EXEC abandons the instruction and clears all state
        preload(3'd2, 8'h5A);
        preload(3'd3, 8'h0F);
        bus.instr       = {3'b100, 3'd2, 3'd3};
        bus.instr_valid = 1'b1;
        @(negedge clk);
        check("rst_test_accept", bus.instr_ready, 32'd1);
        @(posedge clk) #1;
        bus.instr_valid = 1'b0;
        @(posedge clk) #1;
        reset = 1'b1;
        @(posedge clk) #1;
        @(negedge clk);
        check("exec_rst_valid", bus.res_valid, 32'd0);
        check("exec_rst_ready", bus.instr_ready, 32'd0);
        check("exec_rst_outputs", {bus.alu_operand1, bus.alu_operand2, bus.alu_operation,
              bus.res_data, bus.res_hi, bus.res_rd, bus.res_err}, 32'd0);
        for (int i = 0; i < 8; i++) check("exec_rst_regfile", dut.r_regs[i], 32'd0);
        check("exec_rst_hi", dut.r_hi, 32'd0);
        @(posedge clk) #1;
        reset = 1'b0;
        for (int i = 0; i < 8; i++) m_regs[i] = '0;
        m_hi = '0;
        @(negedge clk);
        check("post_rst_ready", bus.instr_ready, 32'd1);
        @(posedge clk) #1;
        issue(3'b011, 3'd2, 3'd3, 0);

        check("sb_drained", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
